// File: rtl/cta_pkg.sv
// Shared types and width helpers for the CTA allocator's CAM update path.
package cta_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SCAN  = 2'd2,
    WRITE = 2'd3
  } scan_state_t;

  // Bitmap words held per CU.
  function automatic int words_of(input int res_id_width, input int word_width);
    return (1 << res_id_width) / word_width;
  endfunction

  // Width of the word index. It is kept at least one bit wide, so a
  // single-word bitmap still has a legal (constant zero) index.
  function automatic int word_idx_width(input int res_id_width, input int word_width);
    int words;
    words = words_of(res_id_width, word_width);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cam_update_scanner_free_run_tracker.sv
// Tracks the current free run and the longest run seen so far, one slot per cycle.
// The best_len/best_start outputs already include the slot presented this cycle,
// so the caller can capture the final result on the same edge that consumes slot N-1.
module free_run_tracker
  import cta_pkg::*;
#(
  parameter int RES_ID_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    free,
  input  logic [RES_ID_WIDTH-1:0] slot,
  input  logic                    first,
  input  logic                    last,
  output logic [RES_ID_WIDTH:0]   best_len,
  output logic [RES_ID_WIDTH-1:0] best_start
);

  logic [RES_ID_WIDTH:0]   cur_len, kept_len, base_len, base_kept_len, run_len;
  logic [RES_ID_WIDTH-1:0] cur_start, kept_start, base_start, base_kept_start, run_start;
  logic                    close_run;

  // Extend or close the current run; first slot starts from a clean slate.
  always_comb begin
    base_len        = first ? '0 : cur_len;
    base_start      = first ? '0 : cur_start;
    base_kept_len   = first ? '0 : kept_len;
    base_kept_start = first ? '0 : kept_start;
    if (free) begin
      run_len   = base_len + 1'b1;
      run_start = (base_len == '0) ? slot : base_start;
    end else begin
      run_len   = base_len;
      run_start = base_start;
    end
    close_run = !free || last;
    // Strictly greater keeps the earliest run on ties.
    if (close_run && (run_len > base_kept_len)) begin
      best_len   = run_len;
      best_start = run_start;
    end else begin
      best_len   = base_kept_len;
      best_start = base_kept_start;
    end
  end

  // Commit the run state for each scanned slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_len    <= '0;
      cur_start  <= '0;
      kept_len   <= '0;
      kept_start <= '0;
    end else if (en) begin
      cur_len    <= close_run ? '0 : run_len;
      cur_start  <= run_start;
      kept_len   <= best_len;
      kept_start <= best_start;
    end
  end

endmodule

// File: rtl/cam_update_scanner.sv
// Scans one CU's occupancy bitmap and writes its largest free segment into the CAM.
module cam_update_scanner
  import cta_pkg::*;
#(
  parameter int  RES_ID_WIDTH = 10,
  parameter int  WORD_WIDTH   = 32,
  parameter int  CU_ID_WIDTH  = 4,
  localparam int WORDS        = words_of(RES_ID_WIDTH, WORD_WIDTH),
  localparam int WIDX_W       = word_idx_width(RES_ID_WIDTH, WORD_WIDTH),
  localparam int BIT_W        = $clog2(WORD_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid_i,
  input  logic [CU_ID_WIDTH-1:0]        req_cu_i,
  output logic                          req_ready_o,
  output logic                          busy_o,
  output logic [CU_ID_WIDTH-1:0]        scan_cu_o,
  output logic                          bm_rd_en_o,
  output logic [CU_ID_WIDTH+WIDX_W-1:0] bm_rd_addr_o,
  input  logic [WORD_WIDTH-1:0]         bm_rd_data_i,
  output logic                          cam_wr_en_o,
  output logic [CU_ID_WIDTH-1:0]        cam_wr_addr_o,
  output logic [RES_ID_WIDTH:0]         cam_wr_data_o,
  output logic [RES_ID_WIDTH-1:0]       cam_wr_start_o
);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_PREF  = BIT_W'(WORD_WIDTH - 2);
  localparam logic [WIDX_W-1:0] WORD_LAST = WIDX_W'(WORDS - 1);

  scan_state_t             state;
  logic [BIT_W-1:0]        bit_idx, bit_nxt;
  logic [WIDX_W-1:0]       word_idx, word_nxt, word_pref;
  logic [WORD_WIDTH-1:0]   word_reg, next_buf, word_now;
  logic                    rd_pend, slot_free, first, last, scanning, issue_next;
  logic [RES_ID_WIDTH-1:0] slot;
  logic [RES_ID_WIDTH:0]   best_len;
  logic [RES_ID_WIDTH-1:0] best_start;

  // Next walk position and prefetch decision; FETCH lands the walk on slot 0.
  always_comb begin
    bit_nxt  = '0;
    word_nxt = '0;
    if (state == SCAN) begin
      if (bit_idx == BIT_LAST) begin
        word_nxt = word_idx + 1'b1;
      end else begin
        bit_nxt  = bit_idx + 1'b1;
        word_nxt = word_idx;
      end
    end
    word_pref  = word_nxt + 1'b1;
    issue_next = ((state == FETCH) || ((state == SCAN) && !last)) &&
                 (bit_nxt == BIT_PREF) && (word_nxt < WORD_LAST);
  end

  // Word 0 arrives in the cycle of slot 0; later words come from the prefetch buffer.
  always_comb begin
    if (bit_idx == '0) begin
      word_now = (word_idx == '0) ? bm_rd_data_i : next_buf;
    end else begin
      word_now = word_reg;
    end
  end

  assign scanning  = (state == SCAN);
  assign slot_free = ~word_now[bit_idx];
  assign slot      = RES_ID_WIDTH'({word_idx, bit_idx});
  assign first     = scanning && (word_idx == '0) && (bit_idx == '0);
  assign last      = scanning && (word_idx == WORD_LAST) && (bit_idx == BIT_LAST);

  free_run_tracker #(
    .RES_ID_WIDTH(RES_ID_WIDTH)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .en        (scanning),
    .free      (slot_free),
    .slot      (slot),
    .first     (first),
    .last      (last),
    .best_len  (best_len),
    .best_start(best_start)
  );

  // Scan sequencer with registered handshake, read and CAM-write outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_ready_o    <= 1'b1;
      busy_o         <= 1'b0;
      scan_cu_o      <= '0;
      bm_rd_en_o     <= 1'b0;
      bm_rd_addr_o   <= '0;
      cam_wr_en_o    <= 1'b0;
      cam_wr_addr_o  <= '0;
      cam_wr_data_o  <= '0;
      cam_wr_start_o <= '0;
      bit_idx        <= '0;
      word_idx       <= '0;
      word_reg       <= '0;
      next_buf       <= '0;
      rd_pend        <= 1'b0;
    end else begin
      bm_rd_en_o  <= 1'b0;
      cam_wr_en_o <= 1'b0;
      rd_pend     <= bm_rd_en_o;
      if (rd_pend) next_buf <= bm_rd_data_i;
      if (issue_next) begin
        bm_rd_en_o   <= 1'b1;
        bm_rd_addr_o <= {scan_cu_o, word_pref};
      end
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            state        <= FETCH;
            req_ready_o  <= 1'b0;
            busy_o       <= 1'b1;
            scan_cu_o    <= req_cu_i;
            bm_rd_en_o   <= 1'b1;
            bm_rd_addr_o <= {req_cu_i, WIDX_W'(0)};
          end
        end
        FETCH: begin
          state    <= SCAN;
          bit_idx  <= bit_nxt;
          word_idx <= word_nxt;
        end
        SCAN: begin
          bit_idx  <= bit_nxt;
          word_idx <= word_nxt;
          if (bit_idx == '0) word_reg <= word_now;
          if (last) begin
            state          <= WRITE;
            cam_wr_en_o    <= 1'b1;
            cam_wr_addr_o  <= scan_cu_o;
            cam_wr_data_o  <= best_len;
            cam_wr_start_o <= best_start;
          end
        end
        WRITE: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_update_scanner.sv
module tb_cam_update_scanner;
  localparam int RW     = 10;
  localparam int N      = 1 << RW;
  localparam int CUW    = 4;
  localparam int WW0    = 32;
  localparam int WW1    = 2;
  localparam int WORDS0 = N / WW0;
  localparam int WORDS1 = N / WW1;
  localparam int AW0    = CUW + 5;
  localparam int AW1    = CUW + 9;

  logic clk = 1'b0;
  logic rst, req_valid;
  logic [CUW-1:0] req_cu;

  logic ready0, busy0, rd0, wr0;
  logic [CUW-1:0] scu0, waddr0;
  logic [AW0-1:0] addr0;
  logic [WW0-1:0] data0;
  logic [RW:0]    wlen0;
  logic [RW-1:0]  wstart0;

  logic ready1, busy1, rd1, wr1;
  logic [CUW-1:0] scu1, waddr1;
  logic [AW1-1:0] addr1;
  logic [WW1-1:0] data1;
  logic [RW:0]    wlen1;
  logic [RW-1:0]  wstart1;

  always #5 clk = ~clk;

  cam_update_scanner #(.RES_ID_WIDTH(RW), .WORD_WIDTH(WW0), .CU_ID_WIDTH(CUW)) dut0 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_cu_i(req_cu),
    .req_ready_o(ready0), .busy_o(busy0), .scan_cu_o(scu0),
    .bm_rd_en_o(rd0), .bm_rd_addr_o(addr0), .bm_rd_data_i(data0),
    .cam_wr_en_o(wr0), .cam_wr_addr_o(waddr0), .cam_wr_data_o(wlen0), .cam_wr_start_o(wstart0));

  cam_update_scanner #(.RES_ID_WIDTH(RW), .WORD_WIDTH(WW1), .CU_ID_WIDTH(CUW)) dut1 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_cu_i(req_cu),
    .req_ready_o(ready1), .busy_o(busy1), .scan_cu_o(scu1),
    .bm_rd_en_o(rd1), .bm_rd_addr_o(addr1), .bm_rd_data_i(data1),
    .cam_wr_en_o(wr1), .cam_wr_addr_o(waddr1), .cam_wr_data_o(wlen1), .cam_wr_start_o(wstart1));

  // bit = 1 means occupied
  logic [N-1:0] occ_map [16];

  // bitmap RAM: data valid exactly one cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    if (rd0) data0 <= occ_map[addr0[AW0-1:5]][int'(addr0[4:0]) * WW0 +: WW0];
    else     data0 <= WW0'($urandom);
    if (rd1) data1 <= occ_map[addr1[AW1-1:9]][int'(addr1[8:0]) * WW1 +: WW1];
    else     data1 <= WW1'($urandom);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // reference: enumerate every maximal free run, keep the first longest
  function automatic void ref_best(input logic [N-1:0] occ, output int len, output int start);
    len = 0;
    start = 0;
    for (int s = 0; s < N; s++) begin
      if (!occ[s] && (s == 0 || occ[s-1])) begin
        int e;
        e = s;
        while (e < N && !occ[e]) e++;
        if (e - s > len) begin
          len = e - s;
          start = s;
        end
      end
    end
  endfunction

  task automatic set_map(input int cu, input int lo0, input int hi0, input int lo1, input int hi1);
    occ_map[cu] = '1;
    if (lo0 >= 0) for (int s = lo0; s <= hi0; s++) occ_map[cu][s] = 1'b0;
    if (lo1 >= 0) for (int s = lo1; s <= hi1; s++) occ_map[cu][s] = 1'b0;
  endtask

  // Called at a negedge of an IDLE cycle T; returns at the negedge of T+N+3.
  task automatic do_scan(input int cu, input int exp_len, input int exp_start, input string tag,
                         input bit hold, input bit poke_write);
    int nrd0, nrd1, bad0, bad1, nwr0, nwr1, at0, at1;
    nrd0 = 0; nrd1 = 0; bad0 = 0; bad1 = 0; nwr0 = 0; nwr1 = 0; at0 = -1; at1 = -1;
    req_valid = 1'b1;
    req_cu = CUW'(cu);
    check({tag, "_ready0"}, ready0, 1);
    check({tag, "_ready1"}, ready1, 1);
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) req_valid = 1'b0;
      if (rd0) begin
        if (addr0 !== AW0'((cu << 5) | nrd0)) bad0++;
        nrd0++;
      end
      if (rd1) begin
        if (addr1 !== AW1'((cu << 9) | nrd1)) bad1++;
        nrd1++;
      end
      if (wr0) begin nwr0++; if (at0 < 0) at0 = k; end
      if (wr1) begin nwr1++; if (at1 < 0) at1 = k; end
      if (k == 1) begin
        check({tag, "_rd0_first"}, rd0, 1);
        check({tag, "_rd1_first"}, rd1, 1);
        check({tag, "_busy0"}, busy0, 1);
        check({tag, "_scu0"}, scu0, cu);
        check({tag, "_scu1"}, scu1, cu);
      end
      if (k == N + 2) begin
        check({tag, "_len0"}, wlen0, exp_len);
        check({tag, "_start0"}, wstart0, exp_start);
        check({tag, "_waddr0"}, waddr0, cu);
        check({tag, "_len1"}, wlen1, exp_len);
        check({tag, "_start1"}, wstart1, exp_start);
        check({tag, "_waddr1"}, waddr1, cu);
        if (poke_write) req_valid = 1'b1;
      end
      if (k == N + 3) begin
        check({tag, "_ready0_after"}, ready0, 1);
        check({tag, "_ready1_after"}, ready1, 1);
        check({tag, "_busy0_after"}, busy0, 0);
        check({tag, "_busy1_after"}, busy1, 0);
        check({tag, "_len0_hold"}, wlen0, exp_len);
        check({tag, "_start1_hold"}, wstart1, exp_start);
      end
    end
    check({tag, "_nrd0"}, nrd0, WORDS0);
    check({tag, "_nrd1"}, nrd1, WORDS1);
    check({tag, "_addr_order0"}, bad0, 0);
    check({tag, "_addr_order1"}, bad1, 0);
    check({tag, "_nwr0"}, nwr0, 1);
    check({tag, "_nwr1"}, nwr1, 1);
    check({tag, "_wr_at0"}, at0, N + 2);
    check({tag, "_wr_at1"}, at1, N + 2);
  endtask

  task automatic reset_mid_scan(input int cu);
    int nwr, nrd;
    nwr = 0; nrd = 0;
    req_valid = 1'b1;
    req_cu = CUW'(cu);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (401) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready0", ready0, 1);
    check("rst_mid_busy1", busy1, 0);
    check("rst_mid_len0", wlen0, 0);
    check("rst_mid_addr1", addr1, 0);
    repeat (N + 8) begin
      @(negedge clk);
      if (wr0 || wr1) nwr++;
      if (rd0 || rd1) nrd++;
    end
    check("rst_mid_no_write", nwr, 0);
    check("rst_mid_no_read", nrd, 0);
  endtask

  typedef struct {
    int cu;
    int lo0, hi0, lo1, hi1;
    int exp_len, exp_start;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int rlen, rstart, cu, p, nruns;
    rst = 1'b1;
    req_valid = 1'b0;
    req_cu = '0;
    repeat (3) @(negedge clk);
    check("reset_ready0", ready0, 1);
    check("reset_ready1", ready1, 1);
    check("reset_busy0", busy0, 0);
    check("reset_rd0", rd0, 0);
    check("reset_wr1", wr1, 0);
    check("reset_scu0", scu0, 0);
    check("reset_addr0", addr0, 0);
    check("reset_waddr1", waddr1, 0);
    check("reset_len0", wlen0, 0);
    check("reset_start1", wstart1, 0);
    rst = 1'b0;

    vecs.push_back('{3, 0, N - 1, -1, -1, 1024, 0});
    vecs.push_back('{0, -1, -1, -1, -1, 0, 0});
    vecs.push_back('{1, 100, 163, 500, 627, 128, 500});
    vecs.push_back('{2, 200, 263, 700, 763, 64, 200});
    vecs.push_back('{4, 30, 33, -1, -1, 4, 30});
    vecs.push_back('{6, 1000, 1023, -1, -1, 24, 1000});
    vecs.push_back('{5, 0, N - 1, -1, -1, 1024, 0});
    vecs.push_back('{7, 0, 0, -1, -1, 1, 0});
    vecs.push_back('{15, 31, 31, 1023, 1023, 1, 31});

    foreach (vecs[i]) begin
      set_map(vecs[i].cu, vecs[i].lo0, vecs[i].hi0, vecs[i].lo1, vecs[i].hi1);
      do_scan(vecs[i].cu, vecs[i].exp_len, vecs[i].exp_start, $sformatf("vec%0d", i), 1'b0, i == 2);
    end

    // held request: the second scan is taken exactly at T+N+3
    set_map(9, 10, 20, -1, -1);
    do_scan(9, 11, 10, "held_a", 1'b1, 1'b0);
    do_scan(9, 11, 10, "held_b", 1'b0, 1'b0);

    reset_mid_scan(3);
    set_map(10, 0, 0, 1023, 1023);
    do_scan(10, 1, 0, "post_rst", 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      cu = int'($urandom_range(0, 15));
      p = int'($urandom_range(1, 9));
      for (int s = 0; s < N; s++) occ_map[cu][s] = ($urandom_range(0, 9) < p);
      nruns = int'($urandom_range(0, 3));
      for (int j = 0; j < nruns; j++) begin
        int lo, ln;
        lo = int'($urandom_range(0, N - 1));
        ln = int'($urandom_range(1, 80));
        for (int s = lo; s < lo + ln && s < N; s++) occ_map[cu][s] = 1'b0;
      end
      ref_best(occ_map[cu], rlen, rstart);
      do_scan(cu, rlen, rstart, $sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
